// File: rtl/osd_scm_rstctrl.sv
// Subnet control module reset controller: static hold registers plus a one-shot
// pulse engine driving the system reset and per-CPU resets via 16-bit register access.
module osd_scm_rstctrl #(
    parameter int SYSTEM_VENDOR_ID = 0,
    parameter int SYSTEM_DEVICE_ID = 0,
    parameter int NUM_MOD          = 1,
    parameter int MAX_PKT_LEN      = 8,
    parameter int NUM_CPU          = 1,
    parameter int PULSE_DEFAULT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_request,
    input  logic               reg_write,
    input  logic [15:0]        reg_addr,
    input  logic [1:0]         reg_size,
    input  logic [15:0]        reg_wdata,
    output logic               reg_ack,
    output logic               reg_err,
    output logic [15:0]        reg_rdata,
    output logic               sys_rst,
    output logic [NUM_CPU-1:0] cpu_rst
);

    localparam logic [15:0] ADDR_VENDOR    = 16'h0200;
    localparam logic [15:0] ADDR_DEVICE    = 16'h0201;
    localparam logic [15:0] ADDR_NUM_MOD   = 16'h0202;
    localparam logic [15:0] ADDR_MAX_PKT   = 16'h0203;
    localparam logic [15:0] ADDR_HOLD      = 16'h0204;
    localparam logic [15:0] ADDR_CPU_HOLD  = 16'h0205;
    localparam logic [15:0] ADDR_PULSE_SYS = 16'h0206;
    localparam logic [15:0] ADDR_PULSE_CPU = 16'h0207;
    localparam logic [15:0] ADDR_PULSE_LEN = 16'h0208;
    localparam logic [15:0] ADDR_NUM_CPU   = 16'h0209;
    localparam logic [15:0] ADDR_STATUS    = 16'h020A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic               pulse_sys_q, pulse_sys_d;
    logic [NUM_CPU-1:0] pulse_cpu_q, pulse_cpu_d;
    logic [1:0]         hold_q, hold_d;
    logic [NUM_CPU-1:0] cpu_hold_mask_q, cpu_hold_mask_d;
    logic [15:0]        pulse_len_q, pulse_len_d;

    logic               busy;
    logic               addr_valid;
    logic               addr_ro;
    logic               is_trigger;
    logic               err;
    logic               acc_wr;
    logic               acc_rd;
    logic               trig_sys;
    logic [NUM_CPU-1:0] trig_cpu;
    logic               trig_fire;
    logic [15:0]        len_load;
    logic [15:0]        mask_ext;
    logic               pulse_on;

    assign busy = (state_q != IDLE);

    always_comb begin
        addr_valid = 1'b0;
        addr_ro    = 1'b0;
        is_trigger = 1'b0;
        case (reg_addr)
            ADDR_VENDOR, ADDR_DEVICE, ADDR_NUM_MOD, ADDR_MAX_PKT,
            ADDR_NUM_CPU, ADDR_STATUS: begin
                addr_valid = 1'b1;
                addr_ro    = 1'b1;
            end
            ADDR_HOLD, ADDR_CPU_HOLD, ADDR_PULSE_LEN: begin
                addr_valid = 1'b1;
            end
            ADDR_PULSE_SYS, ADDR_PULSE_CPU: begin
                addr_valid = 1'b1;
                is_trigger = 1'b1;
            end
            default: begin
                addr_valid = 1'b0;
            end
        endcase
    end

    // A trigger arriving while a pulse is still running is refused rather than queued.
    assign err = (reg_size != 2'd0) | ~addr_valid | (reg_write & addr_ro)
               | (reg_write & is_trigger & busy);

    assign reg_ack = reg_request & ~err;
    assign reg_err = reg_request & err;
    assign acc_wr  = reg_request & reg_write & ~err;
    assign acc_rd  = reg_request & ~reg_write & ~err;

    always_comb begin
        mask_ext                = '0;
        mask_ext[NUM_CPU-1:0]   = cpu_hold_mask_q;
        reg_rdata               = '0;
        if (acc_rd) begin
            case (reg_addr)
                ADDR_VENDOR:    reg_rdata = 16'(SYSTEM_VENDOR_ID);
                ADDR_DEVICE:    reg_rdata = 16'(SYSTEM_DEVICE_ID);
                ADDR_NUM_MOD:   reg_rdata = 16'(NUM_MOD);
                ADDR_MAX_PKT:   reg_rdata = 16'(MAX_PKT_LEN);
                ADDR_HOLD:      reg_rdata = {14'd0, hold_q};
                ADDR_CPU_HOLD:  reg_rdata = mask_ext;
                ADDR_PULSE_LEN: reg_rdata = pulse_len_q;
                ADDR_NUM_CPU:   reg_rdata = 16'(NUM_CPU);
                ADDR_STATUS:    reg_rdata = {15'd0, busy};
                default:        reg_rdata = '0;
            endcase
        end
    end

    always_comb begin
        trig_sys = 1'b0;
        trig_cpu = '0;
        if (reg_addr == ADDR_PULSE_SYS) begin
            trig_sys = reg_wdata[0];
            trig_cpu = reg_wdata[1] ? '1 : '0;
        end else if (reg_addr == ADDR_PULSE_CPU) begin
            trig_cpu = reg_wdata[NUM_CPU-1:0];
        end
    end

    assign trig_fire = acc_wr & is_trigger & (trig_sys | (|trig_cpu));
    assign len_load  = (pulse_len_q == 16'd0) ? 16'd1 : pulse_len_q;

    always_comb begin
        hold_d          = hold_q;
        cpu_hold_mask_d = cpu_hold_mask_q;
        pulse_len_d     = pulse_len_q;
        if (acc_wr) begin
            case (reg_addr)
                ADDR_HOLD:      hold_d          = reg_wdata[1:0];
                ADDR_CPU_HOLD:  cpu_hold_mask_d = reg_wdata[NUM_CPU-1:0];
                ADDR_PULSE_LEN: pulse_len_d     = reg_wdata;
                default:        hold_d          = hold_q;
            endcase
        end
    end

    // Length is sampled only at launch, so rewriting PULSE_LEN mid-pulse affects the next one.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pulse_sys_d = pulse_sys_q;
        pulse_cpu_d = pulse_cpu_q;
        case (state_q)
            IDLE: begin
                if (trig_fire) begin
                    state_d     = PULSE;
                    count_d     = len_load;
                    pulse_sys_d = trig_sys;
                    pulse_cpu_d = trig_cpu;
                end
            end
            PULSE: begin
                count_d = count_q - 16'd1;
                if (count_q <= 16'd1) begin
                    state_d     = GAP;
                    count_d     = '0;
                    pulse_sys_d = 1'b0;
                    pulse_cpu_d = '0;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                count_d     = '0;
                pulse_sys_d = 1'b0;
                pulse_cpu_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            count_q         <= '0;
            pulse_sys_q     <= 1'b0;
            pulse_cpu_q     <= '0;
            hold_q          <= '0;
            cpu_hold_mask_q <= '0;
            pulse_len_q     <= 16'(PULSE_DEFAULT);
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            pulse_sys_q     <= pulse_sys_d;
            pulse_cpu_q     <= pulse_cpu_d;
            hold_q          <= hold_d;
            cpu_hold_mask_q <= cpu_hold_mask_d;
            pulse_len_q     <= pulse_len_d;
        end
    end

    assign pulse_on = (state_q == PULSE);
    assign sys_rst  = rst | hold_q[0] | (pulse_on & pulse_sys_q);
    assign cpu_rst  = {NUM_CPU{sys_rst | hold_q[1]}} | cpu_hold_mask_q
                    | ({NUM_CPU{pulse_on}} & pulse_cpu_q);

endmodule

// File: tb/tb_osd_scm_rstctrl.sv
// Bench for osd_scm_rstctrl: constant vector table, hand-written pulse/reset
// sequences, then random traffic compared against a cycle-count reference model.
module tb_osd_scm_rstctrl;

    localparam int VID = 16'h1234;
    localparam int DID = 16'hABCD;
    localparam int NMOD = 5;
    localparam int MPKT = 12;
    localparam int NCPU = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_request;
    logic        reg_write;
    logic [15:0] reg_addr;
    logic [1:0]  reg_size;
    logic [15:0] reg_wdata;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;
    logic        sys_rst;
    logic [3:0]  cpu_rst;

    int checks = 0;
    int failures = 0;

    osd_scm_rstctrl #(
        .SYSTEM_VENDOR_ID(VID),
        .SYSTEM_DEVICE_ID(DID),
        .NUM_MOD(NMOD),
        .MAX_PKT_LEN(MPKT),
        .NUM_CPU(NCPU),
        .PULSE_DEFAULT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reg_request(reg_request),
        .reg_write(reg_write),
        .reg_addr(reg_addr),
        .reg_size(reg_size),
        .reg_wdata(reg_wdata),
        .reg_ack(reg_ack),
        .reg_err(reg_err),
        .reg_rdata(reg_rdata),
        .sys_rst(sys_rst),
        .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [15:0] wdata;
        logic        ack;
        logic        err;
        logic [15:0] rdata;
        logic        sys;
        logic [3:0]  cpu;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: pulse tracked as remaining cycles, not as FSM states.
    logic [1:0]  m_hold;
    logic [3:0]  m_mask;
    logic [15:0] m_len;
    int          m_left;
    bit          m_gap;
    bit          m_tsys;
    logic [3:0]  m_tcpu;

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic q, input logic w, input logic [15:0] a,
                           input logic [1:0] s, input logic [15:0] d, input logic ea,
                           input logic ee, input logic [15:0] erd, input logic es,
                           input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.req = q; v.wr = w; v.addr = a; v.size = s; v.wdata = d;
        v.ack = ea; v.err = ee; v.rdata = erd; v.sys = es; v.cpu = ec;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic r, input logic q, input logic w,
                                  input logic [15:0] a, input logic [1:0] s,
                                  input logic [15:0] d);
        rst = r; reg_request = q; reg_write = w; reg_addr = a; reg_size = s; reg_wdata = d;
    endtask

    task automatic check_output(input string name, input logic ea, input logic ee,
                                input logic [15:0] erd, input logic es, input logic [3:0] ec);
        check_val({name, ".ack"}, {15'd0, reg_ack}, {15'd0, ea});
        check_val({name, ".err"}, {15'd0, reg_err}, {15'd0, ee});
        check_val({name, ".rdata"}, reg_rdata, erd);
        check_val({name, ".sys_rst"}, {15'd0, sys_rst}, {15'd0, es});
        check_val({name, ".cpu_rst"}, {12'd0, cpu_rst}, {12'd0, ec});
    endtask

    // One bus cycle: drive after the edge, compare at the falling edge, then clock.
    task automatic step(input logic r, input logic q, input logic w, input logic [15:0] a,
                        input logic [1:0] s, input logic [15:0] d, input logic ea,
                        input logic ee, input logic [15:0] erd, input logic es,
                        input logic [3:0] ec, input string name);
        apply_stimulus(r, q, w, a, s, d);
        @(negedge clk);
        check_output(name, ea, ee, erd, es, ec);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hold = '0; m_mask = '0; m_len = 16'd16; m_left = 0; m_gap = 0;
        m_tsys = 0; m_tcpu = '0;
    endtask

    task automatic model_expect(input logic r, input logic q, input logic w,
                                input logic [15:0] a, input logic [1:0] s,
                                output logic ea, output logic ee, output logic [15:0] erd,
                                output logic es, output logic [3:0] ec);
        bit busy, valid, ro, trig, e;
        busy  = (m_left > 0) || m_gap;
        valid = (a >= 16'h0200) && (a <= 16'h020A);
        ro    = (a <= 16'h0203) || (a == 16'h0209) || (a == 16'h020A);
        trig  = (a == 16'h0206) || (a == 16'h0207);
        e     = (s != 2'd0) || !valid || (w && ro) || (w && trig && busy);
        ea    = q && !e;
        ee    = q && e;
        erd   = '0;
        if (q && !w && !e) begin
            case (a)
                16'h0200: erd = 16'(VID);
                16'h0201: erd = 16'(DID);
                16'h0202: erd = 16'(NMOD);
                16'h0203: erd = 16'(MPKT);
                16'h0204: erd = {14'd0, m_hold};
                16'h0205: erd = {12'd0, m_mask};
                16'h0208: erd = m_len;
                16'h0209: erd = 16'(NCPU);
                16'h020A: erd = {15'd0, busy};
                default:  erd = '0;
            endcase
        end
        es = r || m_hold[0] || (m_left > 0 && m_tsys);
        ec = {4{es || m_hold[1]}} | m_mask | ((m_left > 0) ? m_tcpu : 4'd0);
    endtask

    task automatic model_clock(input logic r, input logic ea, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
        if (r) begin
            model_reset();
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_gap = 1;
                    m_tsys = 0;
                    m_tcpu = '0;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end
            if (ea && w) begin
                case (a)
                    16'h0204: m_hold = d[1:0];
                    16'h0205: m_mask = d[3:0];
                    16'h0208: m_len = d;
                    16'h0206: if (d[1:0] != 2'd0) begin
                        m_tsys = d[0];
                        m_tcpu = d[1] ? 4'hF : 4'h0;
                        m_left = (m_len == 0) ? 1 : int'(m_len);
                    end
                    16'h0207: if (d[3:0] != 4'd0) begin
                        m_tsys = 0;
                        m_tcpu = d[3:0];
                        m_left = (m_len == 0) ? 1 : int'(m_len);
                    end
                    default: m_hold = m_hold;
                endcase
            end
        end
    endtask

    initial begin
        logic        ea, ee, es, r, q, w;
        logic [15:0] erd, a, d;
        logic [1:0]  s;
        logic [3:0]  ec;

        apply_stimulus(1, 0, 0, 16'h0, 2'd0, 16'h0);
        repeat (2) @(posedge clk);
        #1;

        add_vec(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 4'hF);
        add_vec(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0200, 0, 16'h0000, 1, 0, 16'h1234, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0201, 0, 16'h0000, 1, 0, 16'hABCD, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0202, 0, 16'h0000, 1, 0, 16'h0005, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0203, 0, 16'h0000, 1, 0, 16'h000C, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0209, 0, 16'h0000, 1, 0, 16'h0004, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0208, 0, 16'h0000, 1, 0, 16'h0010, 0, 4'h0);
        add_vec(0, 1, 1, 16'h0200, 0, 16'hFFFF, 0, 1, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0200, 0, 16'h0000, 1, 0, 16'h1234, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0200, 1, 16'h0000, 0, 1, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 0, 16'h020B, 0, 16'h0000, 0, 1, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 1, 16'h020B, 0, 16'h0003, 0, 1, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 1, 16'h0205, 0, 16'h0005, 1, 0, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0205, 0, 16'h0000, 1, 0, 16'h0005, 0, 4'h5);
        add_vec(0, 1, 1, 16'h0204, 0, 16'h0001, 1, 0, 16'h0000, 0, 4'h5);
        add_vec(0, 1, 0, 16'h0204, 0, 16'h0000, 1, 0, 16'h0001, 1, 4'hF);
        add_vec(0, 1, 1, 16'h0204, 1, 16'h0000, 0, 1, 16'h0000, 1, 4'hF);
        add_vec(0, 1, 1, 16'h0204, 0, 16'h0002, 1, 0, 16'h0000, 1, 4'hF);
        add_vec(0, 1, 0, 16'h0204, 0, 16'h0000, 1, 0, 16'h0002, 0, 4'hF);
        add_vec(0, 1, 1, 16'h0204, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'hF);
        add_vec(0, 1, 1, 16'h0205, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h5);
        add_vec(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 1, 16'h0206, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 1, 16'h0209, 0, 16'h0001, 0, 1, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 0, 16'h0206, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0);
        add_vec(0, 1, 1, 16'h020A, 0, 16'h0001, 0, 1, 16'h0000, 0, 4'h0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].size,
                 vecs[i].wdata, vecs[i].ack, vecs[i].err, vecs[i].rdata, vecs[i].sys,
                 vecs[i].cpu, $sformatf("vec%0d", i));
        end

        // Three-cycle CPU1 pulse followed by the single gap cycle.
        step(0, 1, 1, 16'h0208, 0, 16'h0003, 1, 0, 16'h0000, 0, 4'h0, "a_len");
        step(0, 1, 1, 16'h0207, 0, 16'h0002, 1, 0, 16'h0000, 0, 4'h0, "a_trig");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0001, 0, 4'h2, $sformatf("a_pulse%0d", i));
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0001, 0, 4'h0, "a_gap");
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0, "a_idle");

        // Retrigger refused mid-pulse; zero length gives a one-cycle pulse.
        step(0, 1, 1, 16'h0206, 0, 16'h0001, 1, 0, 16'h0000, 0, 4'h0, "b_trig");
        step(0, 1, 1, 16'h0206, 0, 16'h0001, 0, 1, 16'h0000, 1, 4'hF, "b_retrig");
        step(0, 1, 1, 16'h0208, 0, 16'h0000, 1, 0, 16'h0000, 1, 4'hF, "b_len0");
        step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 4'hF, "b_pulse3");
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0001, 0, 4'h0, "b_gap");
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0, "b_idle");
        step(0, 1, 1, 16'h0207, 0, 16'h0001, 1, 0, 16'h0000, 0, 4'h0, "b_trig1");
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0001, 0, 4'h1, "b_one");
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0001, 0, 4'h0, "b_gap1");
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0, "b_idle1");

        // Reset in the middle of an all-CPU pulse.
        step(0, 1, 1, 16'h0208, 0, 16'h0005, 1, 0, 16'h0000, 0, 4'h0, "c_len");
        step(0, 1, 1, 16'h0206, 0, 16'h0002, 1, 0, 16'h0000, 0, 4'h0, "c_trig");
        step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'hF, "c_pulse");
        step(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 4'hF, "c_rst");
        step(0, 1, 0, 16'h020A, 0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0, "c_after");
        step(0, 1, 0, 16'h0208, 0, 16'h0000, 1, 0, 16'h0010, 0, 4'h0, "c_len_def");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, $sformatf("c_no_resume%0d", i));

        // Random traffic against the reference model.
        step(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 4'hF, "r_reset");
        model_reset();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            q = ($urandom_range(0, 9) < 8);
            w = $urandom_range(0, 1) == 1;
            a = 16'($urandom_range(16'h01FE, 16'h020C));
            s = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (a == 16'h0208)
                d = 16'($urandom_range(0, 6));
            else if ($urandom_range(0, 3) == 0)
                d = 16'h0000;
            else
                d = 16'($urandom);
            model_expect(r, q, w, a, s, ea, ee, erd, es, ec);
            step(r, q, w, a, s, d, ea, ee, erd, es, ec, $sformatf("rnd%0d", i));
            model_clock(r, ea, w, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
